// File: rtl/sdhci_cmd_seq_pkg.sv
// Shared types, register map and helpers for the SDHCI command sequencer.
package sdhci_cmd_seq_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned BeW     = 4;
  localparam int unsigned IdxW    = 6;
  localparam int unsigned RspW    = 128;
  localparam int unsigned ErrStsW = 16;

  // OBI address/request channel
  typedef struct packed {
    logic             req;
    logic [AddrW-1:0] addr;
    logic             we;
    logic [BeW-1:0]   be;
    logic [DataW-1:0] wdata;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
  } obi_req_t;

  // OBI response channel
  typedef struct packed {
    logic [DataW-1:0] rdata;
    logic             err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  // One register access as issued by the sequencer
  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic             we;
    logic [BeW-1:0]   be;
    logic [DataW-1:0] wdata;
  } xact_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_PSTATE,
    ST_WR_ARG,
    ST_WR_CMD,
    ST_POLL,
    ST_RD_RSP,
    ST_CLR,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_R136 = 2'b01,
    RSP_R48  = 2'b10,
    RSP_R48B = 2'b11
  } rsp_type_e;

  localparam logic [AddrW-1:0] OffPstate  = 32'h24;
  localparam logic [AddrW-1:0] OffArg     = 32'h08;
  localparam logic [AddrW-1:0] OffCmd     = 32'h0C;
  localparam logic [AddrW-1:0] OffRsp0    = 32'h10;
  localparam logic [AddrW-1:0] OffIntStat = 32'h30;

  localparam int unsigned PstateCmdInhibitBit = 0;
  localparam int unsigned IntCmdCompleteBit   = 0;
  localparam int unsigned IntErrSummaryBit    = 15;

  localparam logic [15:0] IntCcClear = 16'h0001;

  // Read access, all byte lanes
  function automatic xact_t rd_xact(input logic [AddrW-1:0] addr);
    return '{addr: addr, we: 1'b0, be: 4'hF, wdata: '0};
  endfunction

  // Write access
  function automatic xact_t wr_xact(input logic [AddrW-1:0] addr, input logic [BeW-1:0] be,
                                    input logic [DataW-1:0] wdata);
    return '{addr: addr, we: 1'b1, be: be, wdata: wdata};
  endfunction

  // Command register word: upper half holds index, check enables and response type
  function automatic logic [DataW-1:0] cmd_reg_word(input logic [IdxW-1:0] idx,
                                                    input logic [1:0] chk,
                                                    input rsp_type_e typ);
    return {2'b00, idx, 2'b00, 1'b0, chk[1], chk[0], 1'b0, typ, 16'h0000};
  endfunction

endpackage

// File: rtl/sdhci_obi_master_port.sv
// Single-outstanding OBI master: holds a request until granted, then waits for rvalid.
module sdhci_obi_master_port
  import sdhci_cmd_seq_pkg::*;
(
  input  logic             clk_o,
  input  logic             rst_no,
  input  logic             start_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             we_i,
  input  logic [BeW-1:0]   be_i,
  input  logic [DataW-1:0] wdata_i,
  output logic             done_o,
  output logic [DataW-1:0] rdata_o,
  output logic             err_o,
  output obi_req_t         obi_req_o,
  input  obi_rsp_t         obi_rsp_i
);

  logic pend_q;
  logic wait_q;
  logic req_c;

  // Request is live in the start cycle and stays up until granted
  assign req_c = start_i | pend_q;

  // Track ungranted request and outstanding response
  always_ff @(posedge clk_o or posedge rst_no) begin
    if (rst_no) begin
      pend_q <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      if (wait_q && obi_rsp_i.rvalid) begin
        wait_q <= 1'b0;
      end
      if (req_c && obi_rsp_i.gnt) begin
        pend_q <= 1'b0;
        wait_q <= 1'b1;
      end else if (start_i) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Address fields come straight from the sequencer's held transaction registers
  always_comb begin
    obi_req_o         = '0;
    obi_req_o.a.req   = req_c;
    obi_req_o.a.addr  = addr_i;
    obi_req_o.a.we    = we_i;
    obi_req_o.a.be    = be_i;
    obi_req_o.a.wdata = wdata_i;
  end

  assign done_o  = wait_q & obi_rsp_i.rvalid;
  assign rdata_o = obi_rsp_i.r.rdata;
  assign err_o   = done_o & obi_rsp_i.r.err;

endmodule

// File: rtl/sdhci_cmd_sequencer.sv
// Issues one non-data SD command through the SDHCI register file over OBI.
module sdhci_cmd_sequencer
  import sdhci_cmd_seq_pkg::*;
#(
  parameter logic [AddrW-1:0] BaseAddr  = 32'h0,
  parameter int unsigned      PollLimit = 1024
) (
  input  logic               clk_o,
  input  logic               rst_no,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [IdxW-1:0]    cmd_index_i,
  input  logic [DataW-1:0]   cmd_arg_i,
  input  logic [1:0]         cmd_rsp_type_i,
  input  logic [1:0]         cmd_chk_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [RspW-1:0]    rsp_data_o,
  output logic               rsp_err_o,
  output logic               rsp_timeout_o,
  output logic [ErrStsW-1:0] rsp_err_status_o,
  output obi_req_t           obi_req_o,
  input  obi_rsp_t           obi_rsp_i,
  output logic               busy_o
);

  localparam int unsigned PollCntW = $clog2(PollLimit + 1);

  seq_state_e           state_q;
  logic [IdxW-1:0]      idx_q;
  logic [DataW-1:0]     arg_q;
  rsp_type_e            rsp_type_q;
  logic [1:0]           chk_q;
  logic [PollCntW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [1:0]           rsp_word_q, rsp_word_d;
  xact_t                xact_q;
  logic                 start_q;
  logic                 cmd_ready_q;
  logic                 busy_q;
  logic                 rsp_valid_q;
  logic [RspW-1:0]      rsp_data_q;
  logic                 rsp_err_q;
  logic                 rsp_timeout_q;
  logic [ErrStsW-1:0]   rsp_err_status_q;

  logic                 port_done;
  logic                 port_err;
  logic [DataW-1:0]     port_rdata;

  sdhci_obi_master_port u_port (
    .clk_o     (clk_o),
    .rst_no    (rst_no),
    .start_i   (start_q),
    .addr_i    (xact_q.addr),
    .we_i      (xact_q.we),
    .be_i      (xact_q.be),
    .wdata_i   (xact_q.wdata),
    .done_o    (port_done),
    .rdata_o   (port_rdata),
    .err_o     (port_err),
    .obi_req_o (obi_req_o),
    .obi_rsp_i (obi_rsp_i)
  );

  // Saturating poll count and next response word index
  always_comb begin
    poll_cnt_d = (poll_cnt_q == PollCntW'(PollLimit)) ? poll_cnt_q : poll_cnt_q + PollCntW'(1);
    rsp_word_d = rsp_word_q + 2'd1;
  end

  // Command sequencing FSM; each state advances on completion of its OBI access
  always_ff @(posedge clk_o or posedge rst_no) begin
    if (rst_no) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      arg_q            <= '0;
      rsp_type_q       <= RSP_NONE;
      chk_q            <= '0;
      poll_cnt_q       <= '0;
      rsp_word_q       <= '0;
      xact_q           <= '0;
      start_q          <= 1'b0;
      cmd_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_err_q        <= 1'b0;
      rsp_timeout_q    <= 1'b0;
      rsp_err_status_q <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            idx_q            <= cmd_index_i;
            arg_q            <= cmd_arg_i;
            rsp_type_q       <= rsp_type_e'(cmd_rsp_type_i);
            chk_q            <= cmd_chk_i;
            poll_cnt_q       <= '0;
            rsp_word_q       <= '0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b0;
            rsp_timeout_q    <= 1'b0;
            rsp_err_status_q <= '0;
            cmd_ready_q      <= 1'b0;
            busy_q           <= 1'b1;
            state_q          <= ST_RD_PSTATE;
            start_q          <= 1'b1;
            xact_q           <= rd_xact(BaseAddr + OffPstate);
          end
        end
        ST_DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          if (port_done && port_err) begin
            // Bus error aborts the command with no status snapshot
            rsp_err_q        <= 1'b1;
            rsp_timeout_q    <= 1'b0;
            rsp_err_status_q <= '0;
            rsp_valid_q      <= 1'b1;
            state_q          <= ST_DONE;
          end else if (port_done) begin
            unique case (state_q)
              ST_RD_PSTATE: begin
                start_q <= 1'b1;
                if (port_rdata[PstateCmdInhibitBit]) begin
                  xact_q <= rd_xact(BaseAddr + OffPstate);
                end else begin
                  xact_q  <= wr_xact(BaseAddr + OffArg, 4'hF, arg_q);
                  state_q <= ST_WR_ARG;
                end
              end
              ST_WR_ARG: begin
                start_q <= 1'b1;
                xact_q  <= wr_xact(BaseAddr + OffCmd, 4'hC, cmd_reg_word(idx_q, chk_q, rsp_type_q));
                state_q <= ST_WR_CMD;
              end
              ST_WR_CMD: begin
                start_q <= 1'b1;
                xact_q  <= rd_xact(BaseAddr + OffIntStat);
                state_q <= ST_POLL;
              end
              ST_POLL: begin
                poll_cnt_q <= poll_cnt_d;
                if (port_rdata[IntErrSummaryBit]) begin
                  rsp_err_q        <= 1'b1;
                  rsp_err_status_q <= port_rdata[31:16];
                  start_q          <= 1'b1;
                  xact_q           <= wr_xact(BaseAddr + OffIntStat, 4'hF,
                                              {port_rdata[31:16], IntCcClear});
                  state_q          <= ST_CLR;
                end else if (port_rdata[IntCmdCompleteBit]) begin
                  start_q <= 1'b1;
                  if (rsp_type_q == RSP_NONE) begin
                    xact_q  <= wr_xact(BaseAddr + OffIntStat, 4'hF, {16'h0000, IntCcClear});
                    state_q <= ST_CLR;
                  end else begin
                    xact_q  <= rd_xact(BaseAddr + OffRsp0);
                    state_q <= ST_RD_RSP;
                  end
                end else if (poll_cnt_d >= PollCntW'(PollLimit)) begin
                  // Timed out: leave interrupt status untouched
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_DONE;
                end else begin
                  start_q <= 1'b1;
                  xact_q  <= rd_xact(BaseAddr + OffIntStat);
                end
              end
              ST_RD_RSP: begin
                rsp_data_q[{rsp_word_q, 5'd0} +: 32] <= port_rdata;
                start_q <= 1'b1;
                if (rsp_type_q == RSP_R136 && rsp_word_q != 2'd3) begin
                  rsp_word_q <= rsp_word_d;
                  xact_q     <= rd_xact(BaseAddr + OffRsp0 + {28'd0, rsp_word_d, 2'b00});
                end else begin
                  xact_q  <= wr_xact(BaseAddr + OffIntStat, 4'hF, {16'h0000, IntCcClear});
                  state_q <= ST_CLR;
                end
              end
              ST_CLR: begin
                rsp_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign busy_o           = busy_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_timeout_o    = rsp_timeout_q;
  assign rsp_err_status_o = rsp_err_status_q;

endmodule

// File: tb/tb_sdhci_cmd_sequencer.sv
// Directed bench for sdhci_cmd_sequencer against a small SDHCI register slave model.
module tb_sdhci_cmd_sequencer;
  import sdhci_cmd_seq_pkg::*;

  logic         clk_o = 1'b0;
  logic         rst_no = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready_o;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   cmd_rsp_type = '0;
  logic [1:0]   cmd_chk = '0;
  logic         rsp_valid_o;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data_o;
  logic         rsp_err_o;
  logic         rsp_timeout_o;
  logic [15:0]  rsp_err_status_o;
  obi_req_t     obi_req;
  obi_rsp_t     obi_rsp;
  logic         busy_o;

  // Slave model configuration (written by the stimulus only)
  logic         stall_en = 1'b0;
  int           inh_n = 0;
  int           cc_at = 1;
  logic [31:0]  stat_val = 32'h1;
  logic [31:0]  rsp_regs [4];
  logic         err_en = 1'b0;
  logic [31:0]  err_addr = '0;

  // Slave model state
  logic         gnt_en = 1'b1;
  logic         s_rvalid = 1'b0;
  logic         s_err = 1'b0;
  logic [31:0]  s_rdata = '0;
  int           inh_seen = 0;
  int           poll_n = 0;
  int           log_n = 0;
  logic [31:0]  log_addr  [32];
  logic         log_we    [32];
  logic [3:0]   log_be    [32];
  logic [31:0]  log_wdata [32];

  int n_cmp = 0;
  int n_mis = 0;

  sdhci_cmd_sequencer #(.BaseAddr(32'h0), .PollLimit(4)) dut (
    .clk_o            (clk_o),
    .rst_no           (rst_no),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_index_i      (cmd_index),
    .cmd_arg_i        (cmd_arg),
    .cmd_rsp_type_i   (cmd_rsp_type),
    .cmd_chk_i        (cmd_chk),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_data_o       (rsp_data_o),
    .rsp_err_o        (rsp_err_o),
    .rsp_timeout_o    (rsp_timeout_o),
    .rsp_err_status_o (rsp_err_status_o),
    .obi_req_o        (obi_req),
    .obi_rsp_i        (obi_rsp),
    .busy_o           (busy_o)
  );

  always #5 clk_o = ~clk_o;

  // Grant gating, randomised when stalls are enabled
  always @(negedge clk_o) gnt_en <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;

  always_comb begin
    obi_rsp         = '0;
    obi_rsp.gnt     = obi_req.a.req & gnt_en;
    obi_rsp.rvalid  = s_rvalid;
    obi_rsp.r.rdata = s_rdata;
    obi_rsp.r.err   = s_err;
  end

  // Register slave: logs granted accesses, answers one cycle later
  always @(posedge clk_o) begin
    s_rvalid <= 1'b0;
    s_err    <= 1'b0;
    if (cmd_valid && cmd_ready_o) begin
      log_n    <= 0;
      inh_seen <= 0;
      poll_n   <= 0;
    end else if (obi_req.a.req && gnt_en) begin
      if (log_n < 32) begin
        log_addr[log_n]  <= obi_req.a.addr;
        log_we[log_n]    <= obi_req.a.we;
        log_be[log_n]    <= obi_req.a.be;
        log_wdata[log_n] <= obi_req.a.wdata;
      end
      log_n    <= log_n + 1;
      s_rvalid <= 1'b1;
      s_err    <= err_en && (obi_req.a.addr == err_addr);
      s_rdata  <= '0;
      if (!obi_req.a.we) begin
        case (obi_req.a.addr)
          32'h24: begin
            s_rdata  <= (inh_seen < inh_n) ? 32'h1 : 32'h0;
            inh_seen <= inh_seen + 1;
          end
          32'h30: begin
            s_rdata <= (cc_at != 0 && poll_n + 1 >= cc_at) ? stat_val : 32'h0;
            poll_n  <= poll_n + 1;
          end
          32'h10, 32'h14, 32'h18, 32'h1C: s_rdata <= rsp_regs[obi_req.a.addr[3:2]];
          default: s_rdata <= '0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command, wait for accept, return the cycle in which rsp_valid rose
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input logic [1:0] chkb, output int cyc);
    int g;
    @(negedge clk_o);
    cmd_index    = idx;
    cmd_arg      = arg;
    cmd_rsp_type = typ;
    cmd_chk      = chkb;
    cmd_valid    = 1'b1;
    g = 0;
    while (!cmd_ready_o && g < 100) begin
      @(negedge clk_o);
      g++;
    end
    check("accept", 128'(cmd_ready_o), 128'(1));
    @(posedge clk_o);
    #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid_o && cyc < 300) begin
      @(posedge clk_o);
      #1;
      cyc++;
    end
    check("rsp_valid", 128'(rsp_valid_o), 128'(1));
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk_o);
    #1;
    rsp_ready = 1'b0;
    check("idle_busy", 128'(busy_o), 128'(0));
    check("idle_valid", 128'(rsp_valid_o), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int g;
    for (int i = 0; i < 4; i++) rsp_regs[i] = '0;

    // Reset values
    #1 rst_no = 1'b1;
    repeat (3) @(posedge clk_o);
    @(negedge clk_o);
    check("rst_ready", 128'(cmd_ready_o), 128'(0));
    check("rst_obi", 128'(obi_req), 128'(0));
    check("rst_valid", 128'(rsp_valid_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_data", rsp_data_o, 128'(0));
    check("rst_err", 128'({rsp_err_o, rsp_timeout_o, rsp_err_status_o}), 128'(0));
    rst_no = 1'b0;
    @(negedge clk_o);
    check("ready_after_rst", 128'(cmd_ready_o), 128'(1));

    // CMD0, no response, CC on first poll
    inh_n = 0; cc_at = 1; stat_val = 32'h1;
    run_cmd(6'd0, 32'h0, 2'b00, 2'b00, cyc);
    check("cmd0_cycle", 128'(cyc), 128'(11));
    check("cmd0_err", 128'({rsp_err_o, rsp_timeout_o}), 128'(0));
    check("cmd0_data", rsp_data_o, 128'(0));
    check("cmd0_nxact", 128'(log_n), 128'(5));
    check("cmd0_arg", 128'({log_addr[1], log_we[1], log_be[1], log_wdata[1]}),
          128'({32'h08, 1'b1, 4'hF, 32'h0}));
    check("cmd0_cmd", 128'({log_addr[2], log_we[2], log_be[2], log_wdata[2]}),
          128'({32'h0C, 1'b1, 4'hC, 32'h0}));
    check("cmd0_clr", 128'({log_addr[4], log_we[4], log_wdata[4]}), 128'({32'h30, 1'b1, 32'h1}));
    release_rsp();

    // CMD8 R48 with checks, CC on third poll
    inh_n = 0; cc_at = 3;
    rsp_regs[0] = 32'h0000_01AA; rsp_regs[1] = 32'hDEAD_0001;
    rsp_regs[2] = 32'hDEAD_0002; rsp_regs[3] = 32'hDEAD_0003;
    run_cmd(6'd8, 32'h1AA, 2'b10, 2'b11, cyc);
    check("cmd8_cycle", 128'(cyc), 128'(17));
    check("cmd8_cmdword", 128'(log_wdata[2]), 128'(32'h081A_0000));
    check("cmd8_argword", 128'(log_wdata[1]), 128'(32'h0000_01AA));
    check("cmd8_data", rsp_data_o, 128'(32'h0000_01AA));
    check("cmd8_err", 128'(rsp_err_o), 128'(0));
    check("cmd8_nxact", 128'(log_n), 128'(8));
    release_rsp();

    // CMD2 R136 with one inhibited PSTATE read
    inh_n = 1; cc_at = 1;
    rsp_regs[0] = 32'hAAAA_0001; rsp_regs[1] = 32'hBBBB_0002;
    rsp_regs[2] = 32'hCCCC_0003; rsp_regs[3] = 32'hDDDD_0004;
    run_cmd(6'd2, 32'h0, 2'b01, 2'b00, cyc);
    check("cmd2_cycle", 128'(cyc), 128'(21));
    check("cmd2_data", rsp_data_o, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    check("cmd2_cmdword", 128'(log_wdata[3]), 128'(32'h0201_0000));
    check("cmd2_rsp3_addr", 128'(log_addr[8]), 128'(32'h1C));
    check("cmd2_clr_addr", 128'({log_addr[9], log_we[9]}), 128'({32'h30, 1'b1}));
    check("cmd2_nxact", 128'(log_n), 128'(10));
    release_rsp();

    // Error summary in interrupt status
    inh_n = 0; cc_at = 1; stat_val = 32'h0001_8000;
    run_cmd(6'd17, 32'h200, 2'b10, 2'b11, cyc);
    check("errs_cycle", 128'(cyc), 128'(11));
    check("errs_flags", 128'({rsp_err_o, rsp_timeout_o}), 128'({1'b1, 1'b0}));
    check("errs_status", 128'(rsp_err_status_o), 128'(16'h0001));
    check("errs_clr", 128'({log_addr[4], log_we[4], log_wdata[4]}), 128'({32'h30, 1'b1, 32'h0001_0001}));
    check("errs_nxact", 128'(log_n), 128'(5));
    check("errs_data", rsp_data_o, 128'(0));
    release_rsp();

    // Poll timeout at the limit of 4, no clear
    cc_at = 0; stat_val = 32'h1;
    run_cmd(6'd55, 32'h0, 2'b10, 2'b00, cyc);
    check("tmo_cycle", 128'(cyc), 128'(15));
    check("tmo_flags", 128'({rsp_err_o, rsp_timeout_o}), 128'({1'b1, 1'b1}));
    check("tmo_status", 128'(rsp_err_status_o), 128'(0));
    check("tmo_nxact", 128'(log_n), 128'(7));
    check("tmo_last", 128'({log_addr[6], log_we[6]}), 128'({32'h30, 1'b0}));
    release_rsp();

    // OBI error on the argument write
    cc_at = 1; err_en = 1'b1; err_addr = 32'h08;
    run_cmd(6'd1, 32'h1234, 2'b10, 2'b00, cyc);
    err_en = 1'b0;
    check("obierr_cycle", 128'(cyc), 128'(5));
    check("obierr_flags", 128'({rsp_err_o, rsp_timeout_o, rsp_err_status_o}), 128'({1'b1, 1'b0, 16'h0}));
    check("obierr_nxact", 128'(log_n), 128'(2));
    release_rsp();

    // Grant stalls, reset pulse while the command write is pending
    stall_en = 1'b1;
    @(negedge clk_o);
    cmd_index = 6'd17; cmd_arg = 32'h400; cmd_rsp_type = 2'b10; cmd_chk = 2'b11;
    cmd_valid = 1'b1;
    @(posedge clk_o);
    #1;
    cmd_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk_o);
      g++;
    end while (!(obi_req.a.req && obi_req.a.addr == 32'h0C) && g < 200);
    check("saw_wr_cmd", 128'(obi_req.a.req && obi_req.a.addr == 32'h0C), 128'(1));
    rst_no = 1'b1;
    #1;
    check("rstmid_req", 128'(obi_req.a.req), 128'(0));
    check("rstmid_busy", 128'(busy_o), 128'(0));
    @(negedge clk_o);
    rst_no = 1'b0;
    @(negedge clk_o);
    check("rstmid_ready", 128'(cmd_ready_o), 128'(1));

    // Clean command after the reset, stalls still active
    cc_at = 2; stat_val = 32'h1; rsp_regs[0] = 32'h0000_0900;
    run_cmd(6'd17, 32'h200, 2'b10, 2'b11, cyc);
    check("post_data", rsp_data_o, 128'(32'h0000_0900));
    check("post_err", 128'({rsp_err_o, rsp_timeout_o}), 128'(0));
    check("post_nxact", 128'(log_n), 128'(7));
    check("post_cmdword", 128'(log_wdata[2]), 128'(32'h111A_0000));
    check("post_argword", 128'(log_wdata[1]), 128'(32'h0000_0200));
    release_rsp();
    stall_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
